// File: rtl/noc_packet_injector.sv
// NoC source-side injector: turns a PE packet request into header + payload flits for the router.
// Define NOC_INJ_TAIL_EN to append an XOR checksum tail flit to every packet.
module noc_packet_injector #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            router_x,
    input  logic [4:0]            router_y,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            req_dest_x,
    input  logic [4:0]            req_dest_y,
    input  logic [7:0]            req_len,
    input  logic [DATA_WIDTH-1:0] pl_data,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    output logic [DATA_WIDTH-1:0] flit_data,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  flit_last,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StBody,
        StDrain
`ifdef NOC_INJ_TAIL_EN
        , StTail
`endif
    } state_e;

`ifdef NOC_INJ_TAIL_EN
    localparam bit TailEn = 1'b1;
`else
    localparam bit TailEn = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] flit_data_q, flit_data_d;
    logic                  flit_valid_q, flit_valid_d;
    logic                  flit_last_q, flit_last_d;
    logic [7:0]            remain_q, remain_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic [DATA_WIDTH-1:0] hdr;
    logic                  xfer;
`ifdef NOC_INJ_TAIL_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d      = state_q;
        flit_data_d  = flit_data_q;
        flit_valid_d = flit_valid_q;
        flit_last_d  = flit_last_q;
        remain_d     = remain_q;
        pkt_count_d  = pkt_count_q;
        pl_ready     = 1'b0;
`ifdef NOC_INJ_TAIL_EN
        csum_d       = csum_q;
`endif
        hdr          = '0;
        hdr[27:0]    = {req_len, router_x, router_y, req_dest_x, req_dest_y};
        xfer         = flit_valid_q && flit_ready;

        // A transfer frees the flit register; later loads in this cycle override it.
        if (xfer) begin
            flit_valid_d = 1'b0;
            flit_last_d  = 1'b0;
            if (flit_last_q) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    flit_data_d  = hdr;
                    flit_valid_d = 1'b1;
                    flit_last_d  = (req_len == 8'd0) && !TailEn;
                    remain_d     = req_len;
`ifdef NOC_INJ_TAIL_EN
                    csum_d       = '0;
`endif
                    state_d      = StHead;
                end
            end
            StHead: begin
                if (xfer) begin
                    if (remain_q != 8'd0) begin
                        state_d = StBody;
                    end else begin
`ifdef NOC_INJ_TAIL_EN
                        state_d = StTail;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
            StBody: begin
                pl_ready = !flit_valid_q || flit_ready;
                if (pl_valid && pl_ready) begin
                    flit_data_d  = pl_data;
                    flit_valid_d = 1'b1;
                    flit_last_d  = (remain_q == 8'd1) && !TailEn;
                    remain_d     = remain_q - 8'd1;
`ifdef NOC_INJ_TAIL_EN
                    csum_d       = csum_q ^ pl_data;
`endif
                    if (remain_q == 8'd1) begin
`ifdef NOC_INJ_TAIL_EN
                        state_d = StTail;
`else
                        state_d = StDrain;
`endif
                    end
                end
            end
`ifdef NOC_INJ_TAIL_EN
            StTail: begin
                if (!flit_valid_q || flit_ready) begin
                    flit_data_d  = csum_q;
                    flit_valid_d = 1'b1;
                    flit_last_d  = 1'b1;
                    state_d      = StDrain;
                end
            end
`endif
            StDrain: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            flit_data_q  <= '0;
            flit_valid_q <= 1'b0;
            flit_last_q  <= 1'b0;
            remain_q     <= 8'd0;
            pkt_count_q  <= 16'd0;
`ifdef NOC_INJ_TAIL_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            flit_data_q  <= flit_data_d;
            flit_valid_q <= flit_valid_d;
            flit_last_q  <= flit_last_d;
            remain_q     <= remain_d;
            pkt_count_q  <= pkt_count_d;
`ifdef NOC_INJ_TAIL_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign flit_data  = flit_data_q;
    assign flit_valid = flit_valid_q;
    assign flit_last  = flit_last_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Scoreboard bench for noc_packet_injector: a driver queues expected flits, a monitor checks them.
module tb_noc_packet_injector;

`ifdef NOC_INJ_TAIL_EN
    localparam bit TailEn = 1'b1;
`else
    localparam bit TailEn = 1'b0;
`endif

    logic        clk, rst_n;
    logic [4:0]  router_x, router_y, req_dest_x, req_dest_y;
    logic        req_valid, req_ready, pl_valid, pl_ready;
    logic [7:0]  req_len;
    logic [31:0] pl_data, flit_data;
    logic        flit_valid, flit_ready, flit_last, busy;
    logic [15:0] pkt_count;

    int          checks   = 0;
    int          failures = 0;
    int          rdy_mode = 2;  // 0 random, 1 high, 2 low
    logic [32:0] exp_q[$];      // {last, data}
    logic [31:0] pl_words[$];
    logic [15:0] exp_pkt = 16'd0;
    logic        prev_v, prev_r, prev_l;
    logic [31:0] prev_d;

    noc_packet_injector #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .router_x(router_x), .router_y(router_y),
        .req_valid(req_valid), .req_ready(req_ready), .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y), .req_len(req_len), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .flit_data(flit_data), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .flit_last(flit_last), .busy(busy), .pkt_count(pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        flit_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       flit_ready = ($urandom_range(0, 2) != 0);
                1:       flit_ready = 1'b1;
                default: flit_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_hdr(input logic [4:0] dx, input logic [4:0] dy,
                                              input logic [7:0] len);
        return 32'(len) * 32'h10_0000 + 32'(router_x) * 32'h8000 + 32'(router_y) * 32'h400
             + 32'(dx) * 32'd32 + 32'(dy);
    endfunction

    // Monitor: every flit transfer is checked against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            chk("busy_vs_req_ready", 64'(busy), 64'(!req_ready));
            chk("pkt_count", 64'(pkt_count), 64'(exp_pkt));
            if (req_ready) begin
                chk("idle_flit_valid", 64'(flit_valid), 64'(0));
                chk("idle_pl_ready", 64'(pl_ready), 64'(0));
            end
            if (flit_valid && !flit_ready) chk("pl_ready_stall", 64'(pl_ready), 64'(0));
            if (prev_v && !prev_r)
                chk("hold", {31'd0, flit_valid, flit_last, flit_data}, {31'd0, 1'b1, prev_l, prev_d});
            if (flit_valid && flit_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flit actual=%0h required=none", flit_data);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("flit_data", 64'(flit_data), 64'(e[31:0]));
                    chk("flit_last", 64'(flit_last), 64'(e[32]));
                    if (flit_last) exp_pkt = exp_pkt + 16'd1;
                end
            end
            prev_v = flit_valid; prev_r = flit_ready; prev_l = flit_last; prev_d = flit_data;
        end
    end

    task automatic do_req(input logic [4:0] dx, input logic [4:0] dy, input logic [7:0] len);
        int n = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_dest_x = dx; req_dest_y = dy; req_len = len;
        while (n < 2000) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        if (n >= 2000) chk("req_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("hdr_valid_latency", 64'(flit_valid), 64'(1));
        chk("hdr_data", 64'(flit_data), 64'(model_hdr(dx, dy, len)));
    endtask

    task automatic send_pkt(input logic [4:0] dx, input logic [4:0] dy);
        logic [7:0]  len;
        logic [31:0] x;
        len = 8'(pl_words.size());
        x = 32'd0;
        exp_q.push_back({(len == 8'd0) && !TailEn, model_hdr(dx, dy, len)});
        foreach (pl_words[i]) begin
            x ^= pl_words[i];
            exp_q.push_back({(i == pl_words.size() - 1) && !TailEn, pl_words[i]});
        end
        if (TailEn) exp_q.push_back({1'b1, x});
        do_req(dx, dy, len);
        foreach (pl_words[i]) begin
            int  n  = 0;
            logic hs = 1'b0;
            pl_data = pl_words[i];
            while (!hs && n < 1000) begin
                pl_valid = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                @(negedge clk);
                hs = pl_valid && pl_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!hs) chk("payload_timeout", 64'(0), 64'(1));
        end
        pl_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; pl_valid = 1'b0; pl_data = '0;
        req_dest_x = '0; req_dest_y = '0; req_len = '0; router_x = 5'd1; router_y = 5'd1;
        #17 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_flit_data", 64'(flit_data), 64'(0));
        chk("rst_flit_valid", 64'(flit_valid), 64'(0));
        chk("rst_flit_last", 64'(flit_last), 64'(0));
        chk("rst_pl_ready", 64'(pl_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));

        rdy_mode = 1;
        pl_words = '{32'h1111_0001, 32'h2222_0002};
        chk("hdr_layout", 64'(model_hdr(5'd3, 5'd2, 8'd2)), 64'(32'h0020_8462));
        send_pkt(5'd3, 5'd2);
        drain();
        chk("pkt_count_first", 64'(pkt_count), 64'(1));

        rdy_mode = 0;
        send_pkt(5'd3, 5'd2);
        drain();

        pl_words.delete();
        rdy_mode = 1;
        send_pkt(5'd4, 5'd7);
        rdy_mode = 0;
        send_pkt(5'd1, 5'd1);  // self-addressed
        drain();

        pl_words = '{32'hA5A5_0001, 32'h0F0F_0003};
        send_pkt(5'd9, 5'd9);
        drain();

        // Abort mid-packet: header of a len=4 packet goes out, then reset.
        rdy_mode = 1;
        exp_q.push_back({1'b0, model_hdr(5'd2, 5'd5, 8'd4)});
        do_req(5'd2, 5'd5, 8'd4);
        drain();
        #1 rst_n = 1'b0;
        #1;
        chk("abort_flit_valid", 64'(flit_valid), 64'(0));
        chk("abort_pkt_count", 64'(pkt_count), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        exp_q.delete();
        exp_pkt = 16'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        pl_words = '{32'hDEAD_BEEF};
        send_pkt(5'd6, 5'd0);
        drain();

        // Counter wrap.
        @(posedge clk);
        #1;
        force dut.pkt_count_q = 16'hFFFF;
        exp_pkt = 16'hFFFF;
        #2 release dut.pkt_count_q;
        pl_words = '{32'h0000_0042};
        send_pkt(5'd0, 5'd3);
        drain();
        chk("pkt_count_wrap", 64'(pkt_count), 64'(0));

        for (int p = 0; p < 40; p++) begin
            router_x = 5'($urandom_range(0, 31));
            router_y = 5'($urandom_range(0, 31));
            rdy_mode = int'($urandom_range(0, 1));
            pl_words.delete();
            for (int k = 0; k < int'($urandom_range(0, 8)); k++) pl_words.push_back($urandom);
            if (p % 7 == 0) send_pkt(router_x, router_y);
            else send_pkt(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
